// File: rtl/stack_ctrl.sv
// Top-of-stack controller for the J1 data/return stacks: T register, storage
// pointer, live-entry count and sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic [DEPTH-1:0] mem_ra,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_wa,
  output logic [WIDTH-1:0] mem_wd
);

  localparam int unsigned CW       = DEPTH + 1;
  localparam int unsigned CAPACITY = (2 ** DEPTH) + 1;

  typedef enum logic [1:0] {
    OP_REPLACE = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_SWAP    = 2'b11
  } op_e;

  logic [DEPTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  op_e              op_s;
  logic [DEPTH-1:0] sp_dec;
  logic             is_empty;
  logic             is_full;
  logic             we_raw;

  assign op_s     = op_e'(op);
  assign sp_dec   = sp_q - DEPTH'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(CAPACITY));

  // Next-state and storage write port; flag set overrides clr_err.
  always_comb begin
    sp_d    = sp_q;
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    we_raw  = 1'b0;
    mem_wa  = sp_q;
    mem_wd  = tos_q;

    if (op_valid) begin
      case (op_s)
        OP_REPLACE: begin
          tos_d = din;
          if (is_empty) count_d = CW'(1);
        end
        OP_PUSH: begin
          we_raw = 1'b1;
          mem_wa = sp_q;
          sp_d   = sp_q + DEPTH'(1);
          tos_d  = din;
          if (is_full) ovf_d = 1'b1;
          else         count_d = count_q + CW'(1);
        end
        OP_POP: begin
          tos_d = mem_rd;
          sp_d  = sp_dec;
          if (is_empty) unf_d = 1'b1;
          else          count_d = count_q - CW'(1);
        end
        OP_SWAP: begin
          we_raw = 1'b1;
          mem_wa = sp_dec;
          tos_d  = mem_rd;
          if (count_q < CW'(2)) unf_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A cycle with reset asserted must never disturb storage.
  assign mem_we = we_raw & ~resetq;

  always_ff @(posedge clk) begin
    if (resetq) begin
      sp_q    <= '0;
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tos    = tos_q;
  assign nos    = mem_rd;
  assign count  = count_q;
  assign empty  = is_empty;
  assign full   = is_full;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign mem_ra = sp_dec;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: stimulus queues hand-computed expectations,
// a monitor compares them after each clock edge against a behavioural storage array.
module tb_stack_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NENT  = 2 ** DEPTH;

  localparam logic [1:0] REP  = 2'b00;
  localparam logic [1:0] PSH  = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] SWP  = 2'b11;

  logic             clk = 1'b0;
  logic             resetq = 1'b1;
  logic             op_valid = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] din = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] tos, nos, mem_rd, mem_wd;
  logic [DEPTH:0]   count;
  logic             empty, full, ovf, unf, mem_we;
  logic [DEPTH-1:0] mem_ra, mem_wa;

  logic [WIDTH-1:0] store [NENT];

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq), .op_valid(op_valid), .op(op), .din(din),
    .clr_err(clr_err), .tos(tos), .nos(nos), .count(count), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf), .mem_ra(mem_ra), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < int'(NENT); i++) store[i] = '0;
  always @(posedge clk) if (mem_we) store[mem_wa] <= mem_wd;
  assign mem_rd = store[mem_ra];

  typedef struct {
    int          tag;
    logic [31:0] tos;
    logic [31:0] nos;
    logic [4:0]  cnt;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [3:0]  ra;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic        s_we;
  logic [3:0]  s_wa;
  logic [31:0] s_wd;

  // Capture the write port as seen by the edge that commits the op.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    s_we <= mem_we;
    s_wa <= mem_wa;
    s_wd <= mem_wd;
  end

  function automatic exp_t mk(input logic [31:0] t, input logic [31:0] n,
                              input int c, input logic o, input logic u,
                              input int ra, input logic we, input int wa,
                              input logic [31:0] wd);
    exp_t e;
    e.tag = 0; e.tos = t; e.nos = n; e.cnt = 5'(c);
    e.empty = (c == 0); e.full = (c == 17);
    e.ovf = o; e.unf = u; e.ra = 4'(ra);
    e.we = we; e.wa = 4'(wa); e.wd = wd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: compare every expectation whose edge has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("tos",    tos,            e.tos);
      chk("nos",    nos,            e.nos);
      chk("count",  32'(count),     32'(e.cnt));
      chk("empty",  32'(empty),     32'(e.empty));
      chk("full",   32'(full),      32'(e.full));
      chk("ovf",    32'(ovf),       32'(e.ovf));
      chk("unf",    32'(unf),       32'(e.unf));
      chk("mem_ra", 32'(mem_ra),    32'(e.ra));
      chk("mem_we", 32'(s_we),      32'(e.we));
      if (e.we) begin
        chk("mem_wa", 32'(s_wa), 32'(e.wa));
        chk("mem_wd", s_wd,      e.wd);
      end
    end
  end

  task automatic drive(input logic rst, input logic v, input logic [1:0] o,
                       input logic [31:0] d, input logic clr, input exp_t e);
    exp_t x;
    @(negedge clk);
    resetq = rst; op_valid = v; op = o; din = d; clr_err = clr;
    x = e;
    x.tag = cyc + 1;
    q.push_back(x);
  endtask

  initial begin
    // Reset with a PUSH presented: write port must stay quiet.
    drive(1, 1, PSH, 32'h99, 0, mk(0, 0, 0, 0, 0, 15, 0, 0, 0));
    // Three pushes.
    drive(0, 1, PSH, 32'h11, 0, mk(32'h11, 0,      1, 0, 0, 0, 1, 0, 0));
    drive(0, 1, PSH, 32'h22, 0, mk(32'h22, 32'h11, 2, 0, 0, 1, 1, 1, 32'h11));
    drive(0, 1, PSH, 32'h33, 0, mk(32'h33, 32'h22, 3, 0, 0, 2, 1, 2, 32'h22));
    // Swap then two pops.
    drive(0, 1, SWP, 0, 0, mk(32'h22, 32'h33, 3, 0, 0, 2, 1, 2, 32'h33));
    drive(0, 1, POP, 0, 0, mk(32'h33, 32'h11, 2, 0, 0, 1, 0, 0, 0));
    drive(0, 1, POP, 0, 0, mk(32'h11, 0,      1, 0, 0, 0, 0, 0, 0));
    // Drain to empty, underflow, replace from empty, clear flags.
    drive(0, 1, POP, 0, 0, mk(0, 0, 0, 0, 0, 15, 0, 0, 0));
    drive(0, 1, POP, 0, 0, mk(0, 0, 0, 0, 1, 14, 0, 0, 0));
    drive(0, 1, REP, 32'hAB, 0, mk(32'hAB, 0, 1, 0, 1, 14, 0, 0, 0));
    drive(0, 0, POP, 0, 1, mk(32'hAB, 0, 1, 0, 0, 14, 0, 0, 0));
    // Clean reset, then fill past capacity.
    drive(1, 0, REP, 0, 0, mk(0, 0, 0, 0, 0, 15, 0, 0, 0));
    for (int k = 1; k <= 18; k++)
      drive(0, 1, PSH, 32'(k), 0,
            mk(32'(k), 32'(k - 1), (k > 17) ? 17 : k, k == 18, 0,
               (k - 1) % 16, 1, (k - 1) % 16, 32'(k - 1)));
    drive(0, 0, PSH, 0, 1, mk(18, 17, 17, 0, 0, 1, 0, 0, 0));
    // Overflow together with clr_err: set wins.
    drive(0, 1, PSH, 32'h55, 1, mk(32'h55, 18, 17, 1, 0, 2, 1, 2, 18));
    // Reset mid-sequence with a PUSH: no write, reset values after.
    drive(1, 1, PSH, 32'h66, 0, mk(0, 15, 0, 0, 0, 15, 0, 0, 0));
    // Swap with a single entry flags underflow but still executes.
    drive(0, 1, PSH, 32'h7, 0, mk(32'h7, 0, 1, 0, 0, 0, 1, 0, 0));
    drive(0, 1, SWP, 0, 0, mk(0, 32'h7, 1, 0, 1, 0, 1, 0, 32'h7));
    // Idle with op=PUSH must not write or change state.
    drive(0, 0, PSH, 32'hEE, 0, mk(0, 32'h7, 1, 0, 1, 0, 0, 0, 0));

    @(negedge clk);
    op_valid = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Top-of-stack controller for the J1 data and return stacks. Holds the top element (T) in a register and manages the pointer into the `stack` storage array, which holds every entry below T and is read combinationally. The core issues one stack operation per cycle; this block drives the storage write port and exposes T and N (next-on-stack) to the ALU. It also keeps an element count and sticky overflow/underflow flags.

## Interface
- `WIDTH`, default 32: data width; must match the storage instance.
- `DEPTH`, default 4: storage address bits, so the storage holds 2**DEPTH entries. Total capacity is 2**DEPTH+1 entries, including T.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `resetq` input, 1 bit: synchronous, active-high reset.
- `op_valid` input, 1 bit: perform `op` this cycle.
- `op` input, 2 bits: 00 REPLACE, 01 PUSH, 10 POP, 11 SWAP.
- `din` input, WIDTH bits: new T value for REPLACE and PUSH.
- `clr_err` input, 1 bit: clear the `ovf` and `unf` flags.
- `tos` output, WIDTH bits: T, registered.
- `nos` output, WIDTH bits: N, equal to `mem_rd` (combinational).
- `count` output, DEPTH+1 bits: number of live entries, 0..2**DEPTH+1.
- `empty` output, 1 bit: count==0.
- `full` output, 1 bit: count==2**DEPTH+1.
- `ovf` output, 1 bit: sticky overflow flag.
- `unf` output, 1 bit: sticky underflow flag.
- `mem_ra` output, DEPTH bits: storage read address.
- `mem_rd` input, WIDTH bits: storage read data (asynchronous).
- `mem_we` output, 1 bit: storage write enable.
- `mem_wa` output, DEPTH bits: storage write address.
- `mem_wd` output, WIDTH bits: storage write data.

## Operation
- Internal state:
  - `sp`, DEPTH bits: next free storage slot. Wraps modulo 2**DEPTH.
  - T register.
  - `count`.
  - `ovf` and `unf` flags.
- `mem_ra` = sp-1 (mod 2**DEPTH) at all times, so `nos` = storage[sp-1].
- REPLACE:
  - T <= din.
  - No storage write; sp is unchanged.
  - count <= (count==0) ? 1 : count.
- PUSH:
  - Storage write: mem_we=1, mem_wa=sp, mem_wd=T.
  - sp <= sp+1; T <= din.
  - If not full, count <= count+1. If full, count holds, ovf <= 1, and the oldest entry is silently overwritten (circular).
- POP:
  - T <= nos; sp <= sp-1.
  - If count>0, count <= count-1. If count==0, count holds at 0, unf <= 1, and T takes whatever storage returns.
- SWAP:
  - T <= nos.
  - Storage write: mem_we=1, mem_wa=sp-1, mem_wd=T.
  - sp and count are unchanged.
  - If count<2, unf <= 1; the operation is still performed.
- op_valid=0: no state change, and mem_we=0.
- mem_we is 0 in every cycle except a valid PUSH or SWAP.
- Flags: `ovf` and `unf` are sticky; `clr_err` clears them. If an error is raised in the same cycle as `clr_err`, the set wins.
- Reset (resetq=1 at a rising edge):
  - sp=0, T=0, count=0, ovf=0, unf=0.
  - mem_we is forced to 0 during any cycle with resetq=1, and the op in that cycle is discarded.
  - A reset in the middle of a sequence leaves storage contents undefined but unread until they are pushed again.

## Timing
- Every op completes in one cycle. `tos`, `count`, `empty`, `full` and the flags reflect the op after the clock edge that samples it.
- `nos` is valid combinationally whenever sp is stable. After a PUSH, `nos` equals the previous T in the next cycle, because storage write and sp update share the same edge and storage read is asynchronous.
- `empty` and `full` are derived from the registered `count` with no added latency.
- Back-to-back ops in consecutive cycles are supported with no stall; there is no ready signal.
- Reset outputs: tos=0, count=0, empty=1, full=0, ovf=0, unf=0, mem_we=0, mem_ra=2**DEPTH-1.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, count=3, no flags.
- From that state, SWAP -> tos=0x22, nos=0x33, count=3. Then POP twice -> tos=0x11, count=1.
- With DEPTH=4, PUSH 18 values 1..18 -> count saturates at 17, full=1, ovf=1, tos=18, nos=17. Then `clr_err` -> ovf=0.
- From empty, POP -> unf=1, count=0. Then REPLACE 0xAB -> tos=0xAB, count=1, unf still 1.
- PUSH together with `clr_err` while full -> ovf stays 1 (set wins).
- Mid-sequence, assert resetq for one cycle together with op_valid=1 PUSH -> mem_we=0 in that cycle, and all outputs take their reset values the next cycle.
